// File: rtl/fetch.sv
// Y86-64 instruction fetch stage.
// Splits the 10-byte fetch window into icode/ifun/rA/rB/valC, works out the
// next sequential PC, and flags illegal encodings and out-of-range PCs. Every
// output except halt_flag is combinational. halt_flag also includes a sticky
// register, so a halt stays visible after the fetch window moves on.
module fetch (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [63:0]  PC,
    input  logic [0:79]  instr,
    output logic [3:0]   icode,
    output logic [3:0]   ifun,
    output logic [3:0]   rA,
    output logic [3:0]   rB,
    output logic [63:0]  valC,
    output logic [63:0]  valP,
    output logic         imem_error,
    output logic         instr_valid,
    output logic         halt_flag
);

    // Instruction length in bytes for each legal icode.
    function automatic logic [3:0] ilen_f(input logic [3:0] code);
        logic [3:0] len;
        case (code)
            4'h0, 4'h1, 4'h9:       len = 4'd1;
            4'h2, 4'h6, 4'hA, 4'hB: len = 4'd2;
            4'h3, 4'h4, 4'h5:       len = 4'd10;
            4'h7, 4'h8:             len = 4'd9;
            default:                len = 4'd1;
        endcase
        return len;
    endfunction

    // Whether the icode/ifun pair is a legal encoding.
    function automatic logic legal_f(input logic [3:0] code, input logic [3:0] fn);
        logic ok;
        case (code)
            4'h2, 4'h7: ok = (fn <= 4'd6);
            4'h6:       ok = (fn <= 4'd3);
            4'h0, 4'h1, 4'h3, 4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB:
                        ok = (fn == 4'd0);
            default:    ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Whether the instruction has a register-specifier byte.
    function automatic logic has_regs_f(input logic [3:0] code);
        logic r;
        case (code)
            4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB: r = 1'b1;
            default:                                  r = 1'b0;
        endcase
        return r;
    endfunction

    logic [3:0]  raw_icode_s;
    logic [3:0]  raw_ifun_s;
    logic [63:0] valc_long_s;
    logic [63:0] valc_jump_s;
    logic        mem_err_s;
    logic        valid_s;
    logic        halt_now_s;
    logic        halt_r;

    // Raw field extraction and the two little-endian constant layouts.
    always_comb begin
        raw_icode_s = instr[0:3];
        raw_ifun_s  = instr[4:7];
        valc_long_s = 64'd0;
        valc_jump_s = 64'd0;
        for (int k = 0; k < 8; k++) begin
            valc_long_s[8*k +: 8] = instr[8*(k+2) +: 8];
            valc_jump_s[8*k +: 8] = instr[8*(k+1) +: 8];
        end
        mem_err_s  = (PC[63:8] != 56'd0);
        valid_s    = legal_f(raw_icode_s, raw_ifun_s);
        halt_now_s = rst_n && !mem_err_s && (raw_icode_s == 4'h0) && (raw_ifun_s == 4'h0);
    end

    // Output selection: reset, then memory error, then illegal, then normal decode.
    always_comb begin
        icode       = 4'h1;
        ifun        = 4'h0;
        rA          = 4'hF;
        rB          = 4'hF;
        valC        = 64'd0;
        valP        = 64'd0;
        imem_error  = 1'b0;
        instr_valid = 1'b1;
        halt_flag   = 1'b0;
        if (!rst_n) begin
            valP = 64'd0;
        end else if (mem_err_s) begin
            imem_error = 1'b1;
            valP       = PC;
            halt_flag  = halt_r;
        end else if (!valid_s) begin
            icode       = raw_icode_s;
            ifun        = raw_ifun_s;
            valP        = PC + 64'd1;
            instr_valid = 1'b0;
            halt_flag   = halt_r;
        end else begin
            icode = raw_icode_s;
            ifun  = raw_ifun_s;
            if (has_regs_f(raw_icode_s)) begin
                rA = instr[8:11];
                rB = instr[12:15];
            end else begin
                rA = 4'hF;
                rB = 4'hF;
            end
            case (raw_icode_s)
                4'h3, 4'h4, 4'h5: valC = valc_long_s;
                4'h7, 4'h8:       valC = valc_jump_s;
                default:          valC = 64'd0;
            endcase
            valP      = PC + {60'd0, ilen_f(raw_icode_s)};
            halt_flag = halt_r | halt_now_s;
        end
    end

    // Sticky halt: latches once a halt is decoded, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halt_r <= 1'b0;
        end else if (halt_now_s) begin
            halt_r <= 1'b1;
        end else begin
            halt_r <= halt_r;
        end
    end

endmodule

// File: tb/tb_fetch.sv
// Directed bench for the fetch stage. Expected outputs are queued as each
// stimulus is applied and popped for comparison once the outputs settle.
module tb_fetch;

    logic         clk;
    logic         rst_n;
    logic [63:0]  PC;
    logic [0:79]  instr;
    logic [3:0]   icode, ifun, rA, rB;
    logic [63:0]  valC, valP;
    logic         imem_error, instr_valid, halt_flag;

    typedef struct {
        string       tag;
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [63:0] valc;
        logic [63:0] valp;
        logic        merr;
        logic        valid;
        logic        halt;
    } exp_t;

    exp_t sb_q[$];
    int   chk_cnt  = 0;
    int   pass_cnt = 0;
    int   fail_cnt = 0;

    fetch dut (
        .clk(clk), .rst_n(rst_n), .PC(PC), .instr(instr),
        .icode(icode), .ifun(ifun), .rA(rA), .rB(rB),
        .valC(valC), .valP(valP), .imem_error(imem_error),
        .instr_valid(instr_valid), .halt_flag(halt_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push(input string tag, input logic [3:0] ic, input logic [3:0] fn,
                        input logic [3:0] ra, input logic [3:0] rb,
                        input logic [63:0] vc, input logic [63:0] vp,
                        input logic me, input logic va, input logic ha);
        exp_t e;
        e.tag = tag; e.icode = ic; e.ifun = fn; e.ra = ra; e.rb = rb;
        e.valc = vc; e.valp = vp; e.merr = me; e.valid = va; e.halt = ha;
        sb_q.push_back(e);
    endtask

    task automatic cmp(input string tag, input string fld, input logic [63:0] obs, input logic [63:0] exp_v);
        chk_cnt++;
        assert (obs === exp_v) begin
            pass_cnt++;
        end else begin
            fail_cnt++;
            $error("FAIL %s.%s observed=%0h expected=%0h", tag, fld, obs, exp_v);
        end
    endtask

    task automatic check_out();
        exp_t e;
        chk_cnt++;
        assert (sb_q.size() > 0) begin
            pass_cnt++;
        end else begin
            fail_cnt++;
            $error("FAIL scoreboard observed=empty expected=entry");
        end
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            cmp(e.tag, "icode", {60'd0, icode}, {60'd0, e.icode});
            cmp(e.tag, "ifun",  {60'd0, ifun},  {60'd0, e.ifun});
            cmp(e.tag, "rA",    {60'd0, rA},    {60'd0, e.ra});
            cmp(e.tag, "rB",    {60'd0, rB},    {60'd0, e.rb});
            cmp(e.tag, "valC",  valC,           e.valc);
            cmp(e.tag, "valP",  valP,           e.valp);
            cmp(e.tag, "imem_error",  {63'd0, imem_error},  {63'd0, e.merr});
            cmp(e.tag, "instr_valid", {63'd0, instr_valid}, {63'd0, e.valid});
            cmp(e.tag, "halt_flag",   {63'd0, halt_flag},   {63'd0, e.halt});
        end
    endtask

    // Apply a fetch window just after a falling edge and check it settled.
    task automatic step(input logic [63:0] pc, input logic [79:0] bytes);
        @(negedge clk);
        PC    = pc;
        instr = bytes;
        #1;
        check_out();
    endtask

    initial begin
        rst_n = 1'b0;
        PC    = 64'd5;
        instr = 80'h30F20100000000000000;
        #12;
        push("reset", 4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 64'd0, 1'b0, 1'b1, 1'b0);
        check_out();

        @(negedge clk);
        rst_n = 1'b1;
        PC    = 64'd1;
        instr = 80'h20010000000000000000;
        push("cmov", 4'h2, 4'h0, 4'h0, 4'h1, 64'd0, 64'd3, 1'b0, 1'b1, 1'b0);
        #1;
        check_out();

        push("irmovq", 4'h3, 4'h0, 4'hF, 4'h2, 64'd1, 64'd13, 1'b0, 1'b1, 1'b0);
        step(64'd3, 80'h30F20100000000000000);

        push("jmp", 4'h7, 4'h0, 4'hF, 4'hF, 64'h11, 64'd24, 1'b0, 1'b1, 1'b0);
        step(64'd15, 80'h70110000000000000000);

        push("bad_icode", 4'hC, 4'h0, 4'hF, 4'hF, 64'd0, 64'd39, 1'b0, 1'b0, 1'b0);
        step(64'd38, 80'hC0123456789ABCDEF012);

        push("xorq", 4'h6, 4'h3, 4'h4, 4'h5, 64'd0, 64'd102, 1'b0, 1'b1, 1'b0);
        step(64'd100, 80'h6345FFFFFFFFFFFFFFFF);

        push("bad_opq", 4'h6, 4'h4, 4'hF, 4'hF, 64'd0, 64'd51, 1'b0, 1'b0, 1'b0);
        step(64'd50, 80'h64450000000000000000);

        push("bad_cmov", 4'h2, 4'h7, 4'hF, 4'hF, 64'd0, 64'd61, 1'b0, 1'b0, 1'b0);
        step(64'd60, 80'h27120000000000000000);

        push("jxx6", 4'h7, 4'h6, 4'hF, 4'hF, 64'hA0, 64'd79, 1'b0, 1'b1, 1'b0);
        step(64'd70, 80'h76A00000000000000000);

        push("rmmovq", 4'h4, 4'h0, 4'h1, 4'h2, 64'h1122334455667788, 64'd20, 1'b0, 1'b1, 1'b0);
        step(64'd10, 80'h40128877665544332211);

        push("call", 4'h8, 4'h0, 4'hF, 4'hF, 64'h0807060504030201, 64'd9, 1'b0, 1'b1, 1'b0);
        step(64'd0, 80'h80010203040506070899);

        push("ret", 4'h9, 4'h0, 4'hF, 4'hF, 64'd0, 64'd201, 1'b0, 1'b1, 1'b0);
        step(64'd200, 80'h90AB0000000000000000);

        push("popq", 4'hB, 4'h0, 4'h3, 4'hF, 64'd0, 64'd32, 1'b0, 1'b1, 1'b0);
        step(64'd30, 80'hB03F1111111111111111);

        push("imem_err", 4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 64'd256, 1'b1, 1'b1, 1'b0);
        step(64'd256, 80'h30F20100000000000000);

        push("imem_err_hi", 4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 64'h8000000000000010, 1'b1, 1'b1, 1'b0);
        step(64'h8000000000000010, 80'h00000000000000000000);

        push("pc255", 4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 64'd256, 1'b0, 1'b1, 1'b0);
        step(64'd255, 80'h10000000000000000000);

        push("halt", 4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 64'd40, 1'b0, 1'b1, 1'b1);
        step(64'd39, 80'h00000000000000000000);

        push("halt_sticky", 4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 64'd41, 1'b0, 1'b1, 1'b1);
        step(64'd40, 80'h10000000000000000000);

        // Assert reset between clock edges; outputs must follow immediately.
        #1;
        rst_n = 1'b0;
        #1;
        push("async_reset", 4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 64'd0, 1'b0, 1'b1, 1'b0);
        check_out();

        @(negedge clk);
        rst_n = 1'b1;
        push("post_reset", 4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 64'd41, 1'b0, 1'b1, 1'b0);
        #1;
        check_out();

        push("post_reset_clk", 4'hA, 4'h0, 4'h7, 4'hF, 64'd0, 64'd42, 1'b0, 1'b1, 1'b0);
        step(64'd40, 80'hA07F0000000000000000);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/fetch.md
FETCH -- requirements
Module: fetch

Interface
REQ-001 SHALL expose the following ports; one clock; reset is asynchronous and active-low.
- clk  input  1  rising-edge clock; clocks only the sticky halt register
- rst_n  input  1  asynchronous active-low reset
- PC  input  64  byte address of the current instruction
- instr  input  80 (bits [0:79])  10 instruction bytes starting at PC; byte k = instr[8k : 8k+7], byte 0 first
- icode  output  4  instruction code
- ifun  output  4  function code
- rA  output  4  register A specifier
- rB  output  4  register B specifier
- valC  output  64  constant word
- valP  output  64  address of the next sequential instruction
- imem_error  output  1  PC outside the 256-byte instruction memory
- instr_valid  output  1  icode/ifun is a legal Y86-64 encoding
- halt_flag  output  1  halt instruction fetched

Function
REQ-002 SHALL drive all outputs except halt_flag combinationally from PC and instr, so they are valid in the same cycle the PC changes.
REQ-003 SHALL decode the fields as follows:
- icode = instr[0:3]
- ifun = instr[4:7]
- rA = instr[8:11], rB = instr[12:15], only for icodes 2, 3, 4, 5, 6, A and B; otherwise rA = rB = 4'hF.
REQ-004 SHALL assemble valC little-endian:
- icodes 3, 4, 5: valC = {byte9, byte8, ..., byte2}
- icodes 7, 8: valC = {byte8, ..., byte1}
- all other icodes: valC = 0.
REQ-005 SHALL compute valP = PC + length, 64-bit with wrap-around, using these instruction lengths:
- icode 0 halt: 1; icode 1 nop: 1
- icode 2 cmovXX: 2; icode 3 irmovq: 10; icode 4 rmmovq: 10; icode 5 mrmovq: 10
- icode 6 OPq: 2; icode 7 jXX: 9; icode 8 call: 9; icode 9 ret: 1
- icode A pushq: 2; icode B popq: 2.
REQ-006 SHALL assert instr_valid only when all of these hold:
- icode is in 0..B
- ifun is in 0..6 for icodes 2 and 7
- ifun is in 0..3 for icode 6
- ifun is 0 for every other icode.
REQ-007 SHALL, when instr_valid is 0, drive icode/ifun as decoded, rA = rB = F, valC = 0 and valP = PC + 1.
REQ-008 SHALL assert imem_error when PC[63:8] != 0.
REQ-009 SHALL, while imem_error is asserted, force icode = 1, ifun = 0, rA = rB = F, valC = 0, valP = PC and instr_valid = 1; imem_error has priority over REQ-007.
REQ-010 SHALL drive halt_flag = (sticky halt register) OR (icode == 0 AND ifun == 0 AND imem_error == 0).
REQ-011 SHALL set the sticky halt register on a rising clk edge when the current decode is a halt; it stays set until reset.
REQ-012 SHALL decode instr independently of PC alignment; the bytes in instr are taken as already fetched from PC..PC+9.
REQ-013 SHALL leave any upper address bytes supplied for PC above 246 as whatever instr holds; only REQ-008 flags the range.

Reset
REQ-014 SHALL, while rst_n = 0 and asynchronously, clear the sticky halt register and force these outputs:
- icode = 1, ifun = 0, rA = rB = F
- valC = 0, valP = 0
- instr_valid = 1, imem_error = 0, halt_flag = 0.
REQ-015 SHALL resume normal combinational decode immediately on rst_n = 1; the sticky halt register next updates on the first rising clk edge after release.

Verification
REQ-016 SHALL be verified with at least these directed scenarios:
- PC = 1, instr bytes 20 01 ... -> icode 2, ifun 0, rA 0, rB 1, valC 0, valP 3, instr_valid 1.
- PC = 3, bytes 30 F2 01 00 00 00 00 00 00 00 -> icode 3, rA F, rB 2, valC 1, valP 13.
- PC = 15, bytes 70 11 00 00 00 00 00 00 00 -> icode 7, ifun 0, valC 0x11, valP 24, rA = rB = F.
- PC = 38, byte0 C0 -> instr_valid 0, valP 39; byte0 63 at any PC -> OPq xor, valid, length 2; byte0 64 -> instr_valid 0.
- PC = 39, byte0 00 -> halt_flag 1 combinationally, valP 40; after one clk edge, halt_flag stays 1 with next instr = 10; pulling rst_n low -> halt_flag 0 and icode 1 without a clock edge.
- PC = 256 -> imem_error 1, icode 1, valP 256; PC = 255, byte0 10 -> imem_error 0, valP 256.
